// File: rtl/bus_coherence_arbiter.sv
// Dual-CPU memory arbiter: shares one RAM port among two icaches and two dcaches,
// with a one-cycle snoop phase ahead of coherent dcache transactions.
module bus_coherence_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS*WORD_W-1:0] iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] dload,
    input  logic [CPUS-1:0]        cctrans,
    input  logic [CPUS-1:0]        ccwrite,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_SNOOP = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t            r_state, w_next;
    logic              r_dptr, r_iptr, r_gcls, r_gcpu, r_snooped;
    logic [WORD_W-1:0] r_snaddr;
    logic              w_dptr_n, w_iptr_n, w_gcls_n, w_gcpu_n, w_snooped_n;
    logic [WORD_W-1:0] w_snaddr_n;
    logic [CPUS-1:0]   w_dreq;
    logic              w_oth, w_active, w_snoop_on;
    logic [WORD_W-1:0] w_gdaddr, w_giaddr, w_gdstore, w_snoop_val;

    assign w_dreq    = dREN | dWEN | cctrans;
    assign w_oth     = ~r_gcpu;
    assign w_gdaddr  = r_gcpu ? daddr[2*WORD_W-1:WORD_W]  : daddr[WORD_W-1:0];
    assign w_giaddr  = r_gcpu ? iaddr[2*WORD_W-1:WORD_W]  : iaddr[WORD_W-1:0];
    assign w_gdstore = r_gcpu ? dstore[2*WORD_W-1:WORD_W] : dstore[WORD_W-1:0];
    assign w_active  = r_gcls ? (dREN[r_gcpu] | dWEN[r_gcpu]) : iREN[r_gcpu];

    assign iload       = {CPUS{ramload}};
    assign dload       = {CPUS{ramload}};
    assign o_dbg_state = r_state;
    assign ccsnoopaddr = !w_snoop_on ? '0 :
                         (r_gcpu ? {{WORD_W{1'b0}}, w_snoop_val} : {w_snoop_val, {WORD_W{1'b0}}});

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ST_ARB;
            r_dptr    <= 1'b0;
            r_iptr    <= 1'b0;
            r_gcls    <= 1'b0;
            r_gcpu    <= 1'b0;
            r_snooped <= 1'b0;
            r_snaddr  <= '0;
        end else begin
            r_state   <= w_next;
            r_dptr    <= w_dptr_n;
            r_iptr    <= w_iptr_n;
            r_gcls    <= w_gcls_n;
            r_gcpu    <= w_gcpu_n;
            r_snooped <= w_snooped_n;
            r_snaddr  <= w_snaddr_n;
        end
    end

    // Handshake: a cache holds its request (REN/WEN/cctrans) until its wait bit is
    // seen low for one cycle; dropping the request early abandons the transaction.
    always_comb begin
        w_next      = r_state;
        w_dptr_n    = r_dptr;
        w_iptr_n    = r_iptr;
        w_gcls_n    = r_gcls;
        w_gcpu_n    = r_gcpu;
        w_snooped_n = r_snooped;
        w_snaddr_n  = r_snaddr;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        w_snoop_on  = 1'b0;
        w_snoop_val = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (r_state)
            ST_ARB: begin
                if (|w_dreq) begin
                    w_gcls_n    = 1'b1;
                    w_gcpu_n    = (&w_dreq) ? ~r_dptr : w_dreq[1];
                    w_snooped_n = cctrans[w_gcpu_n];
                    w_next      = cctrans[w_gcpu_n] ? ST_SNOOP : ST_XFER;
                end else if (|iREN) begin
                    w_gcls_n    = 1'b0;
                    w_gcpu_n    = (&iREN) ? ~r_iptr : iREN[1];
                    w_snooped_n = 1'b0;
                    w_next      = ST_XFER;
                end
            end
            ST_SNOOP: begin
                if (!w_dreq[r_gcpu]) begin
                    w_next = ST_ARB;
                end else begin
                    ccwait[w_oth] = 1'b1;
                    ccinv[w_oth]  = ccwrite[r_gcpu];
                    w_snoop_on    = 1'b1;
                    w_snoop_val   = w_gdaddr;
                    w_snaddr_n    = w_gdaddr;
                    // A pure upgrade needs no data, so it completes on the snoop itself.
                    if (!dREN[r_gcpu] && !dWEN[r_gcpu]) begin
                        dwait[r_gcpu] = 1'b0;
                        w_dptr_n      = r_gcpu;
                        w_next        = ST_ARB;
                    end else begin
                        w_next = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (!w_active) begin
                    w_next = ST_ARB;
                end else begin
                    if (r_snooped) begin
                        ccwait[w_oth] = 1'b1;
                        w_snoop_on    = 1'b1;
                        w_snoop_val   = r_snaddr;
                    end
                    ramaddr  = r_gcls ? w_gdaddr : w_giaddr;
                    ramWEN   = r_gcls & dWEN[r_gcpu];
                    ramREN   = r_gcls ? (dREN[r_gcpu] & ~dWEN[r_gcpu]) : 1'b1;
                    ramstore = r_gcls ? w_gdstore : '0;
                    if (ramstate == RAM_ACCESS) begin
                        if (r_gcls) begin
                            dwait[r_gcpu] = 1'b0;
                            w_dptr_n      = r_gcpu;
                        end else begin
                            iwait[r_gcpu] = 1'b0;
                            w_iptr_n      = r_gcpu;
                        end
                        w_next = ST_ARB;
                    end
                end
            end
            default: w_next = ST_ARB;
        endcase
    end
endmodule

// File: doc/bus_coherence_arbiter.md
Name: bus_coherence_arbiter

Overview:
- Dual-CPU memory controller core: shares one RAM port among 2 icaches and 2 dcaches and sequences a snoop phase for coherent dcache transactions.
- Sits between the per-CPU caches (flat cache-control signals, index = cpuid) and the RAM model.
- Serves one transaction at a time through the FSM ARB -> SNOOP (optional) -> XFER -> ARB.

Parameters:
- CPUS, 2, number of CPUs. The design is fixed at 2; other values are unsupported.
- WORD_W, 32, data/address width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  icache read request per CPU.
- iaddr  in  CPUS*WORD_W  icache address per CPU.
- iwait  out  CPUS  icache stall; 0 only on the completion cycle.
- iload  out  CPUS*WORD_W  icache read data (ramload broadcast).
- dREN, dWEN  in  CPUS each  dcache read/write request.
- daddr, dstore  in  CPUS*WORD_W each  dcache address / write data.
- dwait  out  CPUS  dcache stall; 0 only on the completion cycle.
- dload  out  CPUS*WORD_W  dcache read data (ramload broadcast).
- cctrans  in  CPUS  dcache coherence-state transition request.
- ccwrite  in  CPUS  transition is toward M (invalidate others).
- ccwait  out  CPUS  block this CPU's dcache; it is being snooped.
- ccinv  out  CPUS  invalidate the snooped address.
- ccsnoopaddr  out  CPUS*WORD_W  snoop address per CPU.
- ramREN, ramWEN  out  1 each  RAM read/write strobe.
- ramaddr, ramstore  out  WORD_W each  RAM address / write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (async, nRST=0): state=ARB, dptr=0, iptr=0, grant cleared.
  - Outputs on reset: iwait=dwait=all 1; ccwait=ccinv=0; ccsnoopaddr=0; ramREN=ramWEN=0; ramaddr=ramstore=0.
- ARB:
  - Candidate set: dcache requests (dREN|dWEN|cctrans) have absolute priority over iREN.
  - Within a class, round-robin: a CPU is preferred if it is != last granted CPU for that class (dptr/iptr). If only one CPU requests, it wins.
  - Winner latches grant {class, cpu}; the pointer updates on completion, not on grant.
  - Next state: SNOOP if winning dcache has cctrans=1, else XFER. No RAM strobes in ARB.
  - Idle (no requests): stay in ARB.
- SNOOP (exactly 1 cycle), with o = other CPU:
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[grant], ccinv[o]=ccwrite[grant].
  - Invalidate-only upgrade (cctrans=1, dREN=dWEN=0): dwait[grant]=0 this cycle, then -> ARB.
  - Otherwise -> XFER.
- XFER:
  - ccwait[o] stays 1 and ccsnoopaddr[o] is held if the transaction passed SNOOP; ccinv=0.
  - RAM drive: ramaddr = granted address; ramREN = iREN or dREN of grant; ramWEN = dWEN (dWEN wins if both dREN and dWEN); ramstore = dstore[grant].
  - ramstate=ACCESS: the granted wait bit is 0 for that cycle, load data is valid, pointer <- granted cpu, -> ARB.
  - BUSY/FREE: hold all outputs.
  - ERROR: hold and retry; do not complete.
- Request withdrawn mid-XFER or mid-SNOOP: drop all strobes, leave waits high, -> ARB next cycle, pointer unchanged.
- Back-to-back transactions: there is always at least one ARB cycle between them.
- Non-granted waits: always 1.
- iload/dload: every entry equals ramload at all times; consumers qualify the data with their wait bit.
- Reset asserted mid-transaction: immediate return to reset values; no completion pulse is generated.

Test Plan:
- Single icache read: CPU0 iREN=1, iaddr=0x100; RAM ACCESS after 2 BUSY cycles -> ramREN=1, ramaddr=0x100 for 3 cycles; iwait[0]=0 for one cycle with iload[0]=ramload; back to ARB.
- Priority: CPU0 iREN and CPU1 dREN asserted together -> CPU1 dcache served first; CPU0 icache served after one ARB cycle.
- Round-robin: both dcaches request continuously, each RAM access takes 1 cycle -> grants alternate 0,1,0,1; neither requester is starved.
- Coherent write-miss: CPU1 dREN=1, cctrans=1, ccwrite=1, daddr=0x2000 -> SNOOP cycle with ccwait[0]=1, ccinv[0]=1, ccsnoopaddr[0]=0x2000; ccwait[0] held through XFER; dwait[1]=0 on ACCESS.
- Upgrade only: CPU0 cctrans=1, ccwrite=1, no REN/WEN -> ccinv[1]=1 for one cycle, dwait[0]=0 in the same cycle, no RAM strobe.
- ERROR and abort: ramstate=ERROR for 2 cycles then ACCESS -> single completion only after ACCESS; a separate request dropped mid-XFER -> strobes fall next cycle, no wait pulse, pointer unchanged.
